// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry defaults and fill-controller state type
package cache_pkg;

  localparam int CACHE_SIZE_BLOCK = 32;
  localparam int CACHE_BIT_TOTAL  = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    FILL
  } cache_fill_state_t;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// rtl/cache_fill_ctrl_if.sv - compute-side slave, SDRAM master, cache array and stats signals
interface cache_fill_ctrl_if #(
  parameter int SIZE_BLOCK = cache_pkg::CACHE_SIZE_BLOCK,
  parameter int BIT_TOTAL  = cache_pkg::CACHE_BIT_TOTAL
);
  localparam int BIT_OFFSET = $clog2(SIZE_BLOCK / 8);

  logic                              s_read;
  logic [BIT_TOTAL-1:0]              s_address;
  logic                              s_waitrequest;
  logic [SIZE_BLOCK-1:0]             s_readdata;
  logic                              s_readdatavalid;

  logic                              m_read;
  logic [BIT_TOTAL+BIT_OFFSET-1:0]   m_address;
  logic                              m_waitrequest;
  logic [SIZE_BLOCK-1:0]             m_readdata;
  logic                              m_readdatavalid;

  logic                              c_en;
  logic                              c_wrt;
  logic [BIT_TOTAL-1:0]              c_addr;
  logic [SIZE_BLOCK-1:0]             c_wdata;
  logic [SIZE_BLOCK-1:0]             c_rdata;
  logic                              c_success;

  logic [31:0]                       o_hits;
  logic [31:0]                       o_misses;

  // slave: the fill controller's view; master: the surrounding agents, SDRAM and cache array
  modport slave (
    input  s_read, s_address, m_waitrequest, m_readdata, m_readdatavalid, c_rdata, c_success,
    output s_waitrequest, s_readdata, s_readdatavalid, m_read, m_address,
           c_en, c_wrt, c_addr, c_wdata, o_hits, o_misses
  );

  modport master (
    output s_read, s_address, m_waitrequest, m_readdata, m_readdatavalid, c_rdata, c_success,
    input  s_waitrequest, s_readdata, s_readdatavalid, m_read, m_address,
           c_en, c_wrt, c_addr, c_wdata, o_hits, o_misses
  );

endinterface

// File: rtl/cache_fill_ctrl_sat_counter32.sv
// rtl/cache_fill_ctrl_sat_counter32.sv - 32-bit saturating event counter with synchronous clear
module sat_counter32 (
  input  logic        i_clk,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  always_ff @(posedge i_clk) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - read-miss handler: cache lookup, SDRAM fetch, fill and respond
// Optional hit/miss statistics counters are built when CACHE_FILL_STATS_EN is defined.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int SIZE_BLOCK = CACHE_SIZE_BLOCK,
  parameter int BIT_TOTAL  = CACHE_BIT_TOTAL
) (
  input logic              i_clk,
  input logic              i_rst,
  cache_fill_ctrl_if.slave bus
);

  localparam int BIT_OFFSET = $clog2(SIZE_BLOCK / 8);

  cache_fill_state_t               state_q;
  logic [BIT_TOTAL-1:0]            req_addr_q;
  logic [SIZE_BLOCK-1:0]           fill_data_q;
  logic [SIZE_BLOCK-1:0]           s_readdata_q;
  logic                            s_readdatavalid_q;
  logic                            m_read_q;
  logic [BIT_TOTAL+BIT_OFFSET-1:0] m_address_q;
  logic                            accept;

  assign bus.s_waitrequest = i_rst | (state_q != IDLE);
  assign accept            = bus.s_read & ~bus.s_waitrequest;

  // Cache port is shared: read on accept in IDLE, write during FILL; reset suppresses the write.
  always_comb begin
    bus.c_en    = 1'b0;
    bus.c_wrt   = 1'b0;
    bus.c_addr  = '0;
    bus.c_wdata = '0;
    if (accept) begin
      bus.c_en   = 1'b1;
      bus.c_addr = bus.s_address;
    end else if ((state_q == FILL) && !i_rst) begin
      bus.c_en    = 1'b1;
      bus.c_wrt   = 1'b1;
      bus.c_addr  = req_addr_q;
      bus.c_wdata = fill_data_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q           <= IDLE;
      req_addr_q        <= '0;
      fill_data_q       <= '0;
      s_readdata_q      <= '0;
      s_readdatavalid_q <= 1'b0;
      m_read_q          <= 1'b0;
      m_address_q       <= '0;
    end else begin
      s_readdatavalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_addr_q <= bus.s_address;
            state_q    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (bus.c_success) begin
            s_readdata_q      <= bus.c_rdata;
            s_readdatavalid_q <= 1'b1;
            state_q           <= IDLE;
          end else begin
            m_address_q <= {req_addr_q, {BIT_OFFSET{1'b0}}};
            m_read_q    <= 1'b1;
            state_q     <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (!bus.m_waitrequest) begin
            m_read_q <= 1'b0;
            state_q  <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (bus.m_readdatavalid) begin
            fill_data_q <= bus.m_readdata;
            state_q     <= FILL;
          end
        end
        FILL: begin
          s_readdata_q      <= fill_data_q;
          s_readdatavalid_q <= 1'b1;
          state_q           <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_readdata      = s_readdata_q;
  assign bus.s_readdatavalid = s_readdatavalid_q;
  assign bus.m_read          = m_read_q & ~i_rst;
  assign bus.m_address       = m_address_q;

`ifdef CACHE_FILL_STATS_EN
  logic lookup_hit;
  logic lookup_miss;

  assign lookup_hit  = (state_q == LOOKUP) & bus.c_success;
  assign lookup_miss = (state_q == LOOKUP) & ~bus.c_success;

  sat_counter32 u_hits (
    .i_clk   (i_clk),
    .clr_i   (i_rst),
    .en_i    (lookup_hit),
    .count_o (bus.o_hits)
  );

  sat_counter32 u_misses (
    .i_clk   (i_clk),
    .clr_i   (i_rst),
    .en_i    (lookup_miss),
    .count_o (bus.o_misses)
  );
`else
  assign bus.o_hits   = '0;
  assign bus.o_misses = '0;
`endif

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Read-miss handler for the per-pixel-core read-only data cache. Accepts single-word read requests from intersection/shading modules on an Avalon-MM slave port and performs a one-cycle cache lookup. On a hit it returns cached data; on a miss it fetches the block from SDRAM over an Avalon-MM master port, fills the cache, and returns the fetched data. It sits between the compute-side request agents and the cache array / SDRAM interconnect, with one request outstanding at a time.

## Interface
- SIZE_BLOCK, 32, block/word width in bits; a power of two and at least 8.
- BIT_TOTAL, 24, data-array index width (same index space as the cache).
- BIT_OFFSET, derived, $clog2(SIZE_BLOCK/8); byte-offset bits appended for SDRAM addressing.
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high; clock i_clk
- s_read  in  1  compute-side read request
- s_address  in  BIT_TOTAL  data-array index
- s_waitrequest  out  1  request not accepted this cycle
- s_readdata  out  SIZE_BLOCK  returned word
- s_readdatavalid  out  1  s_readdata valid, one-cycle pulse
- m_read  out  1  SDRAM read request
- m_address  out  BIT_TOTAL+BIT_OFFSET  byte address = {req_addr, BIT_OFFSET'b0}
- m_waitrequest  in  1  SDRAM stall
- m_readdata  in  SIZE_BLOCK  SDRAM data
- m_readdatavalid  in  1  SDRAM data valid
- c_en, c_wrt  out  1 each  cache enable / write select
- c_addr  out  BIT_TOTAL  cache index
- c_wdata  out  SIZE_BLOCK  fill data
- c_rdata  in  SIZE_BLOCK  cache read data (registered, one cycle after c_en)
- c_success  in  1  cache hit or write acknowledge (registered, one cycle after c_en)
- o_hits, o_misses  out  32 each  statistics counters (see Configuration)

## Operation
- States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL.
- s_waitrequest = i_rst | (state != IDLE). A request is accepted when s_read & !s_waitrequest.
- IDLE: on accept, drive c_en=1, c_wrt=0, c_addr=s_address combinationally. Latch req_addr. Go to LOOKUP.
- LOOKUP: c_en=0.
  - If c_success: register s_readdata<=c_rdata, pulse s_readdatavalid, and go to IDLE.
  - Otherwise: register m_address, set m_read=1, and go to MISS_REQ.
- MISS_REQ: hold m_read and m_address stable while m_waitrequest=1. When m_waitrequest=0, clear m_read and go to MISS_WAIT.
- MISS_WAIT: on m_readdatavalid, latch fill_data<=m_readdata and go to FILL.
- FILL: drive c_en=1, c_wrt=1, c_addr=req_addr, c_wdata=fill_data. Register s_readdata<=fill_data and pulse s_readdatavalid. Go to IDLE. The write acknowledge on c_success in the next cycle is ignored.
- m_readdatavalid in any state other than MISS_WAIT is discarded. This covers stray returns after a reset.
- Reset mid-operation: state returns to IDLE, m_read drops immediately, and the pending request is dropped with no response.
- Reset values: s_readdata=0, s_readdatavalid=0, m_read=0, m_address=0, c_en=0, c_wrt=0, c_addr=0, c_wdata=0, o_hits=0, o_misses=0. s_waitrequest=1 while i_rst is asserted.

## Timing
- Accept at edge T. Hit: s_readdatavalid at T+2. Next request can be accepted at T+2.
- Miss with zero SDRAM stall and read latency L (m_readdatavalid L cycles after command acceptance):
  - m_read asserted from T+2.
  - If m_readdatavalid arrives at cycle R, FILL occupies R+1 and s_readdatavalid is high in R+2.
- Cache write and response happen on the same edge.
- Back-to-back throughput: one hit every 2 cycles.

## Configuration
- CACHE_FILL_STATS_EN defined:
  - o_hits increments on each LOOKUP hit.
  - o_misses increments on each LOOKUP miss.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF, and clear on reset.
- Undefined: o_hits and o_misses are tied to 0 and no counter logic is generated. Port list is identical in both builds.

## Structure
- Package cache_pkg: the state enum (cache_fill_state_t) and the shared BIT_TOTAL/SIZE_BLOCK defaults used by the cache and all request agents.
- Sub-module sat_counter32 (enable, clear, saturating count) instantiated twice under CACHE_FILL_STATS_EN.

## Test plan
- Cache model preloaded with index 0x000010=0xDEADBEEF; read 0x000010 -> s_readdatavalid at T+2 with 0xDEADBEEF; m_read never asserted; o_hits=1.
- Read 0x000020 (miss); SDRAM returns 0xCAFEF00D after 3 cycles -> m_address=0x000080, cache written with idx 0x000020 and 0xCAFEF00D; response 0xCAFEF00D. Re-read 0x000020 -> hit at T+2, no m_read.
- Miss with m_waitrequest held high 5 cycles -> m_read and m_address stable throughout; single SDRAM command; s_waitrequest high until the response.
- Reset asserted in MISS_WAIT, then stray m_readdatavalid 0x11111111 two cycles after reset -> no s_readdatavalid, no cache write; next request serviced normally.
- Back-to-back hits with s_read held high for 6 cycles -> 3 accepts, 3 responses, in order, 2 cycles apart.
- With CACHE_FILL_STATS_EN: 4 hits and 2 misses -> o_hits=4, o_misses=2. Without the macro -> both read 0.
